// File: rtl/divider_controller.sv
// Sequencing FSM for the 10-bit restoring divider: load, ten shift/compare/subtract
// iterations, final quotient-bit insert, then a done pulse with dz/ovf flags.
module divider_controller (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bZero,
  input  logic lt,
  input  logic qNotZero,
  input  logic cNine,
  input  logic co,
  output logic sclr,
  output logic ldB,
  output logic ldACC,
  output logic ldQ,
  output logic ldC,
  output logic shLACC,
  output logic shLQ,
  output logic setQ0,
  output logic inc,
  output logic init0,
  output logic ready,
  output logic done,
  output logic dz,
  output logic ovf
);

  typedef enum logic [2:0] {
    S_CLR, S_IDLE, S_LOAD, S_CHECK, S_SHIFT, S_TEST, S_FIX, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic   qb_q, qb_d;
  logic   dz_q, dz_d;
  logic   ovf_q, ovf_d;

  logic sclr_q, sclr_d;
  logic ready_q, ready_d;
  logic done_q, done_d;
  logic load_q, load_d;
  logic shlacc_q, shlacc_d;
  logic shlq_q, shlq_d;
  logic setq0_q, setq0_d;
  logic test_q, test_d;

  // The counter carry cannot assert in a legal run.
  logic unused_co;
  assign unused_co = co;

  always_comb begin
    state_d = state_q;
    qb_d    = qb_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_CLR:   state_d = S_IDLE;
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        qb_d    = 1'b0;
        dz_d    = 1'b0;
        ovf_d   = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bZero) begin
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: state_d = S_TEST;
      S_TEST: begin
        qb_d    = ~lt;
        state_d = cNine ? S_FIX : S_SHIFT;
      end
      S_FIX:   state_d = S_DONE;
      S_DONE: begin
        ovf_d   = ~dz_q & qNotZero;
        state_d = S_IDLE;
      end
      default: state_d = S_CLR;
    endcase
  end

  // Strobes are decoded from the next state so they appear registered in that state.
  always_comb begin
    sclr_d   = (state_d == S_CLR);
    ready_d  = (state_d == S_IDLE);
    done_d   = (state_d == S_DONE);
    load_d   = (state_d == S_LOAD);
    shlacc_d = (state_d == S_SHIFT);
    shlq_d   = (state_d == S_SHIFT) || (state_d == S_FIX);
    setq0_d  = shlq_d & qb_d;
    test_d   = (state_d == S_TEST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_CLR;
      qb_q     <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      sclr_q   <= 1'b1;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      shlacc_q <= 1'b0;
      shlq_q   <= 1'b0;
      setq0_q  <= 1'b0;
      test_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      qb_q     <= qb_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      sclr_q   <= sclr_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      load_q   <= load_d;
      shlacc_q <= shlacc_d;
      shlq_q   <= shlq_d;
      setq0_q  <= setq0_d;
      test_q   <= test_d;
    end
  end

  assign sclr   = sclr_q;
  assign ready  = ready_q;
  assign done   = done_q;
  assign ldB    = load_q;
  assign ldQ    = load_q;
  assign ldC    = load_q;
  assign init0  = load_q;
  assign shLACC = shlacc_q;
  assign shLQ   = shlq_q;
  assign setQ0  = setq0_q;
  // Subtract and increment depend on the comparator/terminal count seen during TEST.
  assign ldACC  = test_q & ~lt;
  assign inc    = test_q & ~cNine;
  assign dz     = dz_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_divider_controller.sv
// Bench for divider_controller: behavioural datapath model plus table-driven divisions
// and hand-written sequences for start re-pulse and mid-run reset.
module tb_divider_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic bZero, lt, qNotZero, cNine;
  logic co = 1'b0;
  logic sclr, ldB, ldACC, ldQ, ldC, shLACC, shLQ, setQ0, inc, init0;
  logic ready, done, dz, ovf;

  always #5 clk = ~clk;

  divider_controller dut (
    .clk(clk), .rst(rst), .start(start),
    .bZero(bZero), .lt(lt), .qNotZero(qNotZero), .cNine(cNine), .co(co),
    .sclr(sclr), .ldB(ldB), .ldACC(ldACC), .ldQ(ldQ), .ldC(ldC),
    .shLACC(shLACC), .shLQ(shLQ), .setQ0(setQ0), .inc(inc), .init0(init0),
    .ready(ready), .done(done), .dz(dz), .ovf(ovf)
  );

  // Datapath model
  logic [9:0]  a_in = 10'd0, b_in = 10'd0;
  logic [9:0]  m_b = 10'd0, m_q = 10'd0;
  logic [10:0] m_acc = 11'd0;
  logic [3:0]  m_cnt = 4'd0;

  always @(posedge clk) begin
    if (sclr) begin
      m_b <= '0; m_q <= '0; m_acc <= '0; m_cnt <= '0;
    end else begin
      if (ldB) m_b <= b_in;
      if (ldQ) m_q <= a_in;
      else if (shLQ) m_q <= {m_q[8:0], setQ0};
      if (init0) m_acc <= '0;
      else if (ldACC) m_acc <= m_acc - {1'b0, m_b};
      else if (shLACC) m_acc <= {m_acc[9:0], m_q[9]};
      if (ldC) m_cnt <= 4'd1;
      else if (inc) m_cnt <= m_cnt + 4'd1;
    end
  end

  always_comb begin
    bZero    = (m_b == 10'd0);
    lt       = (m_acc < {1'b0, m_b});
    cNine    = (m_cnt == 4'd10);
    qNotZero = |m_q[9:4];
  end

  int n_checks = 0;
  int n_fail = 0;
  int viol = 0;
  int done_total = 0;

  always @(negedge clk) begin
    if ((ldACC && shLACC) || (ldQ && shLQ)) viol++;
    if (done) done_total++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0]  a;
    logic [9:0]  b;
    logic [9:0]  q;
    logic [10:0] r;
    logic        dz;
    logic        ovf;
    int          lat;
    int          shq;
    int          shacc;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_ready();
    int k;
    for (k = 0; k < 20 && !ready; k++) @(posedge clk) #1;
    check("ready_wait", int'(ready), 1);
  endtask

  task automatic do_run(input logic [9:0] a, input logic [9:0] b, input bit repulse,
                        output int lat, output int dcnt, output int shq, output int shacc);
    lat = -1; dcnt = 0; shq = 0; shacc = 0;
    wait_ready();
    a_in = a; b_in = b;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      start = (repulse && n >= 6 && n <= 13) ? 1'b1 : 1'b0;
      @(posedge clk) #1;
      if (shLQ) shq++;
      if (shLACC) shacc++;
      if (done) begin
        dcnt++;
        if (lat < 0) lat = n;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, dcnt, shq, shacc, dbefore;
    vecs[0] = '{10'd100,  10'd7,    10'd14,   11'd2, 1'b0, 1'b0, 23, 11, 10};
    vecs[1] = '{10'd1000, 10'd3,    10'd333,  11'd1, 1'b0, 1'b1, 23, 11, 10};
    vecs[2] = '{10'd5,    10'd0,    10'd5,    11'd0, 1'b1, 1'b0, 2,  0,  0};
    vecs[3] = '{10'd5,    10'd9,    10'd0,    11'd5, 1'b0, 1'b0, 23, 11, 10};
    vecs[4] = '{10'd1023, 10'd1,    10'd1023, 11'd0, 1'b0, 1'b1, 23, 11, 10};
    vecs[5] = '{10'd1023, 10'd1023, 10'd1,    11'd0, 1'b0, 1'b0, 23, 11, 10};
    vecs[6] = '{10'd0,    10'd5,    10'd0,    11'd0, 1'b0, 1'b0, 23, 11, 10};

    // Reset state
    #12;
    check("rst_sclr", int'(sclr), 1);
    check("rst_ready", int'(ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_flags", int'({dz, ovf}), 0);
    check("rst_strobes", int'({ldB, ldACC, ldQ, ldC, shLACC, shLQ, setQ0, inc, init0}), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check("clr_to_idle_ready", int'(ready), 1);
    check("clr_to_idle_sclr", int'(sclr), 0);

    for (int i = 0; i < 7; i++) begin
      do_run(vecs[i].a, vecs[i].b, 1'b0, lat, dcnt, shq, shacc);
      $display("run %0d: a=%0d b=%0d -> q=%0d r=%0d dz=%0d ovf=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, m_q, m_acc, dz, ovf, lat);
      check("latency", lat, vecs[i].lat);
      check("done_count", dcnt, 1);
      check("quotient", int'(m_q), int'(vecs[i].q));
      check("remainder", int'(m_acc), int'(vecs[i].r));
      check("dz", int'(dz), int'(vecs[i].dz));
      check("ovf", int'(ovf), int'(vecs[i].ovf));
      check("shLQ_pulses", shq, vecs[i].shq);
      check("shLACC_pulses", shacc, vecs[i].shacc);
    end

    // start re-pulsed during iterations 3..6 must be ignored
    do_run(10'd100, 10'd7, 1'b1, lat, dcnt, shq, shacc);
    $display("repulse run: a=100 b=7 -> q=%0d r=%0d dones=%0d lat=%0d", m_q, m_acc, dcnt, lat);
    check("repulse_done_count", dcnt, 1);
    check("repulse_latency", lat, 23);
    check("repulse_quotient", int'(m_q), 14);
    check("repulse_remainder", int'(m_acc), 2);

    // Reset asserted during the 5th TEST
    wait_ready();
    a_in = 10'd100; b_in = 10'd7;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("midrun_in_test_inc", int'(inc), 1);
    dbefore = done_total;
    rst = 1'b1;
    #1;
    check("midrun_rst_sclr", int'(sclr), 1);
    check("midrun_rst_strobes", int'({ldB, ldACC, ldQ, ldC, shLACC, shLQ, setQ0, inc, init0, done, ready}), 0);
    @(negedge clk) rst = 1'b0;
    #1;
    check("midrun_clr_held", int'(sclr), 1);
    @(posedge clk) #1;
    check("midrun_idle_ready", int'(ready), 1);
    check("midrun_no_done", done_total - dbefore, 0);
    $display("reset run: FSM back in IDLE, q=%0d r=%0d", m_q, m_acc);
    check("midrun_dp_cleared", int'(m_q) + int'(m_acc), 0);

    do_run(10'd100, 10'd7, 1'b0, lat, dcnt, shq, shacc);
    $display("post-reset run: a=100 b=7 -> q=%0d r=%0d lat=%0d", m_q, m_acc, lat);
    check("post_rst_quotient", int'(m_q), 14);
    check("post_rst_remainder", int'(m_acc), 2);
    check("post_rst_latency", lat, 23);

    check("strobe_exclusion_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
